// File: rtl/target_cmd_decoder_if.sv
// rtl/target_cmd_decoder_if.sv - regfile snoop, button and target/result signals of the target command decoder
interface target_cmd_decoder_if #(
  parameter int NUM_TARGETS = 6
);
  logic                   snoop_we;
  logic [4:0]             snoop_rd;
  logic [31:0]            snoop_data;
  logic                   btn;
  logic [NUM_TARGETS-1:0] targets;
  logic                   hit_pulse;
  logic                   miss_pulse;
  logic                   busy;
  logic                   cmd_err;

  modport master (
    output snoop_we, snoop_rd, snoop_data, btn,
    input  targets, hit_pulse, miss_pulse, busy, cmd_err
  );

  modport slave (
    input  snoop_we, snoop_rd, snoop_data, btn,
    output targets, hit_pulse, miss_pulse, busy, cmd_err
  );
endinterface

// File: rtl/target_cmd_decoder.sv
// rtl/target_cmd_decoder.sv - decodes CPU writes to the command register into timed target windows; BTN_DEBOUNCE_EN adds button debounce
module target_cmd_decoder #(
  parameter int CMD_REG         = 29,
  parameter int NUM_TARGETS     = 6,
  parameter int TICK_DIV        = 100000,
  parameter int LOCKOUT_MS      = 200,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic                  clk_i,
  input logic                  reset_ni,
  target_cmd_decoder_if.slave  cmd_if
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_LOCKOUT
  } state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [15:0]            ms_left_q, ms_left_d;
  logic [NUM_TARGETS-1:0] targets_q, targets_d;
  logic                   hit_q, hit_d;
  logic                   miss_q, miss_d;
  logic                   err_q, err_d;
  logic                   sync1_q, sync2_q, prev_q;
  logic                   btn_lvl;
  logic                   press;

  logic                   cmd_wr;
  logic                   cmd_abort;
  logic [2:0]             cmd_idx;
  logic [15:0]            cmd_ms;
  logic                   cmd_ok;
  logic                   tick;
  logic                   unused_cmd_bits;

  assign cmd_wr          = cmd_if.snoop_we && (cmd_if.snoop_rd == 5'(CMD_REG));
  assign cmd_abort       = cmd_if.snoop_data[31];
  assign cmd_idx         = cmd_if.snoop_data[2:0];
  assign cmd_ms          = cmd_if.snoop_data[23:8];
  assign cmd_ok          = ({1'b0, cmd_idx} < 4'(NUM_TARGETS)) && (cmd_ms != 16'd0);
  assign tick            = (presc_q == PW'(TICK_DIV - 1));
  assign unused_cmd_bits = ^{cmd_if.snoop_data[30:24], cmd_if.snoop_data[7:3]};

  // Synchroniser and edge detector idle at 1 so reset never looks like a press.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= cmd_if.btn;
      sync2_q <= sync1_q;
      prev_q  <= btn_lvl;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          db_lvl_q;
  logic [DW-1:0] db_cnt_q;

  // The accepted level follows the synchronised one only after it has disagreed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      db_lvl_q <= 1'b1;
      db_cnt_q <= '0;
    end else if (sync2_q != db_lvl_q) begin
      if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        db_lvl_q <= sync2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end else begin
      db_cnt_q <= '0;
    end
  end

  assign btn_lvl = db_lvl_q;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign btn_lvl = sync2_q;
`endif

  assign press = prev_q & ~btn_lvl;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      ms_left_q <= '0;
      targets_q <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      ms_left_q <= ms_left_d;
      targets_q <= targets_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      err_q     <= err_d;
    end
  end

  // Priority inside a window: abort, then hit, then miss; a rejected command is
  // only flagged when no result pulse goes out, keeping the pulses exclusive.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    ms_left_d = ms_left_q;
    targets_d = targets_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_wr && !cmd_abort) begin
          if (cmd_ok) begin
            state_d   = S_ARMED;
            presc_d   = '0;
            ms_left_d = cmd_ms;
            targets_d = NUM_TARGETS'(1) << cmd_idx;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_ARMED: begin
        if (cmd_wr && cmd_abort) begin
          state_d   = S_IDLE;
          presc_d   = '0;
          ms_left_d = '0;
          targets_d = '0;
        end else begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            ms_left_d = ms_left_q - 16'd1;
          end
          if (press || (tick && ms_left_q == 16'd1)) begin
            hit_d     = press;
            miss_d    = !press;
            state_d   = S_LOCKOUT;
            presc_d   = '0;
            ms_left_d = 16'(LOCKOUT_MS);
            targets_d = '0;
          end else if (cmd_wr) begin
            err_d = 1'b1;
          end
        end
      end

      S_LOCKOUT: begin
        if (cmd_wr && cmd_abort) begin
          state_d   = S_IDLE;
          presc_d   = '0;
          ms_left_d = '0;
        end else begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            ms_left_d = ms_left_q - 16'd1;
            if (ms_left_q == 16'd1) begin
              state_d = S_IDLE;
            end
          end
          err_d = cmd_wr;
        end
      end

      default: begin
        state_d   = S_IDLE;
        targets_d = '0;
      end
    endcase
  end

  assign cmd_if.targets    = targets_q;
  assign cmd_if.hit_pulse  = hit_q;
  assign cmd_if.miss_pulse = miss_q;
  assign cmd_if.cmd_err    = err_q;
  assign cmd_if.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_target_cmd_decoder.sv
// tb/tb_target_cmd_decoder.sv - directed and random stimulus against a cycle-count reference model of target_cmd_decoder
module tb_target_cmd_decoder;
  localparam int TD  = 10;
  localparam int LMS = 3;
  localparam int DB  = 5;
  localparam int NT  = 6;
  localparam int CR  = 29;
`ifdef BTN_DEBOUNCE_EN
  localparam int PRESS_LAT = 2 + DB;
`else
  localparam int PRESS_LAT = 2;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  target_cmd_decoder_if #(.NUM_TARGETS(NT)) bus ();

  target_cmd_decoder #(
    .CMD_REG(CR), .NUM_TARGETS(NT), .TICK_DIV(TD), .LOCKOUT_MS(LMS), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk_i   (clk),
    .reset_ni(reset_n),
    .cmd_if  (bus.slave)
  );

  // Reference model: mode 0 idle, 1 window open, 2 lockout; m_left counts cycles.
  int            m_mode;
  int            m_left;
  logic [NT-1:0] m_targets;
  logic          m_hit, m_miss, m_err;
  logic [2:0]    m_hist;
  logic          m_acc, m_acc_prev;
  int            m_db_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int ev_hit, ev_miss, ev_err, ev_tgt, ev_busy;

  function automatic void model_reset();
    m_mode = 0; m_left = 0; m_targets = '0;
    m_hit = 1'b0; m_miss = 1'b0; m_err = 1'b0;
    m_hist = 3'b111; m_acc = 1'b1; m_acc_prev = 1'b1; m_db_cnt = 0;
  endfunction

  function automatic void model_edge();
    logic press, is_cmd, abort;
    int   idx, ms;
    if (!reset_n) begin
      model_reset();
      return;
    end
`ifdef BTN_DEBOUNCE_EN
    press      = m_acc_prev & ~m_acc;
    m_acc_prev = m_acc;
    if (m_hist[1] != m_acc) begin
      m_db_cnt++;
      if (m_db_cnt == DB) begin
        m_acc    = m_hist[1];
        m_db_cnt = 0;
      end
    end else begin
      m_db_cnt = 0;
    end
`else
    press = m_hist[2] & ~m_hist[1];
`endif
    m_hist = {m_hist[1:0], bus.btn};
    is_cmd = bus.snoop_we && (int'(bus.snoop_rd) == CR);
    abort  = bus.snoop_data[31];
    idx    = int'(bus.snoop_data[2:0]);
    ms     = int'(bus.snoop_data[23:8]);
    m_hit = 1'b0; m_miss = 1'b0; m_err = 1'b0;
    case (m_mode)
      0: if (is_cmd && !abort) begin
        if (idx < NT && ms != 0) begin
          m_mode = 1; m_left = ms * TD; m_targets = NT'(1) << idx;
        end else begin
          m_err = 1'b1;
        end
      end
      1: if (is_cmd && abort) begin
        m_mode = 0; m_targets = '0;
      end else begin
        m_left--;
        if (press || m_left == 0) begin
          m_hit = press; m_miss = !press;
          m_mode = 2; m_left = LMS * TD; m_targets = '0;
        end else if (is_cmd) begin
          m_err = 1'b1;
        end
      end
      default: if (is_cmd && abort) begin
        m_mode = 0;
      end else begin
        m_left--;
        if (m_left == 0) m_mode = 0;
        m_err = is_cmd;
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic compare_all();
    check("targets", 32'(bus.targets), 32'(m_targets));
    check("hit_pulse", 32'(bus.hit_pulse), 32'(m_hit));
    check("miss_pulse", 32'(bus.miss_pulse), 32'(m_miss));
    check("cmd_err", 32'(bus.cmd_err), 32'(m_err));
    check("busy", 32'(bus.busy), 32'(m_mode != 0));
    ev_hit  += int'(bus.hit_pulse);
    ev_miss += int'(bus.miss_pulse);
    ev_err  += int'(bus.cmd_err);
    ev_busy += int'(bus.busy);
  endtask

  task automatic clr_ev();
    ev_hit = 0; ev_miss = 0; ev_err = 0; ev_tgt = 0; ev_busy = 0;
  endtask

  task automatic tick(input logic we, input logic [4:0] rd, input logic [31:0] data, input logic b);
    bus.snoop_we = we; bus.snoop_rd = rd; bus.snoop_data = data; bus.btn = b;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input logic b);
    for (int i = 0; i < n; i++) tick(1'b0, 5'd0, 32'd0, b);
  endtask

  task automatic idle_watch(input int n, input logic [NT-1:0] pat);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 5'd0, 32'd0, 1'b1);
      if (bus.targets == pat) ev_tgt++;
    end
  endtask

  task automatic cmd(input logic [4:0] rd, input logic [31:0] data);
    tick(1'b1, rd, data, 1'b1);
  endtask

  logic        rbtn;
  int          hold;
  logic [31:0] rdata;
  logic [4:0]  rrd;

  initial begin
    model_reset();
    reset_n = 1'b0;
    bus.snoop_we = 1'b0; bus.snoop_rd = '0; bus.snoop_data = '0; bus.btn = 1'b1;
    idle(3, 1'b1);
    reset_n = 1'b1;
    idle(3, 1'b1);

    // Miss: 5 ms on target 2, window of exactly 50 cycles then lockout.
    clr_ev();
    cmd(5'd29, 32'h0000_0502);
    if (bus.targets == 6'b000100) ev_tgt++;
    idle_watch(50 + LMS * TD + 5, 6'b000100);
    check("miss_window_len", 32'(ev_tgt), 32'd50);
    check("miss_count", 32'(ev_miss), 32'd1);
    check("miss_busy_len", 32'(ev_busy), 32'(50 + LMS * TD));

    // Hit, then a second press inside lockout that must be ignored.
    clr_ev();
    cmd(5'd29, 32'h0000_1401);
    idle(30, 1'b1);
    idle(5, 1'b0);
    idle(5, 1'b1);
    idle(5, 1'b0);
    idle(70, 1'b1);
    check("hit_count", 32'(ev_hit), 32'd1);
    check("hit_no_miss", 32'(ev_miss), 32'd0);

    // Rejects: bad index, zero on-time, wrong register.
    clr_ev();
    cmd(5'd29, 32'h0000_0507);
    idle(2, 1'b1);
    cmd(5'd29, 32'h0000_0001);
    idle(2, 1'b1);
    cmd(5'd28, 32'h0000_0502);
    idle(2, 1'b1);
    check("reject_err_count", 32'(ev_err), 32'd2);
    check("reject_idle", 32'(ev_busy), 32'd0);

    // Abort mid-window.
    clr_ev();
    cmd(5'd29, 32'h0000_0302);
    if (bus.targets == 6'b000100) ev_tgt++;
    idle_watch(9, 6'b000100);
    cmd(5'd29, 32'h8000_0000);
    idle_watch(40, 6'b000100);
    check("abort_window_len", 32'(ev_tgt), 32'd10);
    check("abort_no_pulse", 32'(ev_hit + ev_miss + ev_err), 32'd0);

    // New command during the window is rejected and the window runs on.
    clr_ev();
    cmd(5'd29, 32'h0000_0202);
    if (bus.targets == 6'b000100) ev_tgt++;
    idle_watch(4, 6'b000100);
    cmd(5'd29, 32'h0000_0101);
    if (bus.targets == 6'b000100) ev_tgt++;
    idle_watch(50, 6'b000100);
    check("collide_err", 32'(ev_err), 32'd1);
    check("collide_window_len", 32'(ev_tgt), 32'd20);
    check("collide_miss", 32'(ev_miss), 32'd1);

    // Press detected on the final cycle of a 1 ms window: hit wins.
    clr_ev();
    cmd(5'd29, 32'h0000_0101);
    idle(10 - PRESS_LAT - 1, 1'b1);
    idle(8, 1'b0);
    idle(45, 1'b1);
    check("final_cycle_hit", 32'(ev_hit), 32'd1);
    check("final_cycle_no_miss", 32'(ev_miss), 32'd0);

    // Reset asserted mid-window drops targets at once and nothing follows.
    clr_ev();
    cmd(5'd29, 32'h0000_0301);
    idle(5, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_targets", 32'(bus.targets), 32'd0);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    idle(2, 1'b1);
    reset_n = 1'b1;
    idle(40, 1'b1);
    check("rst_no_pulse", 32'(ev_hit + ev_miss), 32'd0);

`ifdef BTN_DEBOUNCE_EN
    clr_ev();
    cmd(5'd29, 32'h0000_1401);
    idle(3, 1'b1);
    idle(3, 1'b0);
    idle(20, 1'b1);
    check("glitch_no_hit", 32'(ev_hit), 32'd0);
    idle(6, 1'b0);
    idle(50, 1'b1);
    check("debounced_hit", 32'(ev_hit), 32'd1);
`endif

    // Random traffic against the model.
    rbtn = 1'b1;
    hold = 5;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        rbtn = ~rbtn;
        hold = $urandom_range(1, 12);
      end
      hold--;
      if ($urandom_range(0, 11) == 0) begin
        rdata        = $urandom();
        rdata[31]    = ($urandom_range(0, 7) == 0);
        rdata[23:8]  = 16'($urandom_range(0, 4));
        rdata[2:0]   = 3'($urandom_range(0, 7));
        rrd          = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31)) : 5'd29;
        tick(1'b1, rrd, rdata, rbtn);
      end else begin
        tick(1'b0, 5'($urandom_range(0, 31)), $urandom(), rbtn);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/target_cmd_decoder.md
Name: target_cmd_decoder

Overview:
- Processor-to-hardware end of the game's register-file side channel. The score path pushes button hits into the CPU; this block consumes commands the CPU writes.
- Snoops the register-file write port for writes to a command register and decodes each write into "light target k for N ms".
- Times the target window and watches the hit button. Reports hit or miss back as single-cycle pulses for the score-injection logic.
- Sits beside the regfile in the top level and drives the target LEDs.

Parameters:
- CMD_REG, 29, register index treated as the command register.
- NUM_TARGETS, 6, number of target LEDs (max 8).
- TICK_DIV, 100000, clk cycles per 1 ms tick (100 MHz clk).
- LOCKOUT_MS, 200, ms after a hit or miss during which commands are rejected and the button is ignored.
- DEBOUNCE_CYCLES, 1000000, stable cycles required before a button level is accepted (only used with BTN_DEBOUNCE_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- snoop_we  in  1  regfile write enable, as actually applied to the regfile.
- snoop_rd  in  5  regfile write address.
- snoop_data  in  32  regfile write data.
- btn  in  1  raw hit button, active-low (0 = pressed).
- targets  out  NUM_TARGETS  one-hot target LEDs, registered.
- hit_pulse  out  1  one-cycle pulse on a valid hit.
- miss_pulse  out  1  one-cycle pulse on a window timeout.
- busy  out  1  high in ARMED or LOCKOUT.
- cmd_err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM = IDLE; all counters 0; button synchroniser preset to 1 (released).
- Command accepted on a cycle with snoop_we=1 and snoop_rd==CMD_REG.
- Command format:
  - [2:0] target index
  - [23:8] on-time in ms (16-bit unsigned)
  - [31] abort
  - other bits ignored
- Button: 2-FF synchroniser. A press event is a 1->0 transition of the synchronised level.
- FSM IDLE:
  - Valid command (abort=0, index<NUM_TARGETS, on-time!=0) -> ARMED.
  - Load ms_left=on-time, clear the tick prescaler, latch the index.
  - targets one-hot for that index from the next cycle (1-cycle latency).
  - Invalid command (index>=NUM_TARGETS or on-time==0) -> cmd_err next cycle; stay IDLE.
  - Abort in IDLE: no-op, no cmd_err.
- FSM ARMED:
  - Prescaler counts 0..TICK_DIV-1; at wrap, ms_left decrements.
  - Press event -> hit_pulse next cycle; targets=0; -> LOCKOUT.
  - ms_left reaches 0 -> miss_pulse next cycle; targets=0; -> LOCKOUT.
  - Press and timeout on the same cycle: hit wins; no miss_pulse.
  - Abort command -> targets=0; -> IDLE; no hit or miss pulse.
  - Non-abort command -> cmd_err; window unaffected.
- FSM LOCKOUT:
  - Counts LOCKOUT_MS ms, then -> IDLE. Press events are ignored.
  - Abort -> IDLE immediately.
  - Non-abort command -> cmd_err.
- Window length: exactly on-time*TICK_DIV cycles from the first targets-high cycle to the cycle targets drops on a miss.
- Press events in IDLE are ignored.
- hit_pulse, miss_pulse and cmd_err are mutually exclusive and never exceed one cycle.
- Reset asserted mid-window: targets drop immediately; no pulse issued.

Optional Feature:
- Macro: BTN_DEBOUNCE_EN.
- Defined: after the synchroniser, the accepted button level changes only after the raw level has been stable for DEBOUNCE_CYCLES consecutive cycles. Press events come from the debounced level, adding DEBOUNCE_CYCLES latency to hit_pulse.
- Undefined: press events come directly from the synchroniser output; no debounce logic is instantiated.

Test Plan:
- Reset mid-ARMED: drop reset low while targets!=0 -> targets=0 asynchronously; no hit_pulse or miss_pulse after release.
- Miss (TICK_DIV=10): write 0x00000502 to r29 -> targets=6'b000100 one cycle later, held exactly 50 cycles; miss_pulse 1 cycle; busy for a further LOCKOUT_MS*10 cycles.
- Hit: write 0x00001401, pull btn low 30 cycles later -> hit_pulse 2-3 cycles after the press, targets=0, no miss_pulse. A second press during LOCKOUT produces nothing.
- Rejects: write 0x00000507 (index 7) -> cmd_err 1 cycle, targets stay 0. Write 0x00000001 (on-time 0) -> cmd_err. A valid write to r28 -> no effect.
- Abort and collision: during ARMED, write 0x80000000 -> targets=0, IDLE, no pulses. New command during ARMED -> cmd_err, window continues. Press on the final ms cycle -> hit_pulse only.
- With BTN_DEBOUNCE_EN (DEBOUNCE_CYCLES=5): 3-cycle glitch low -> no hit. 6-cycle low -> one hit_pulse.
